// File: rtl/pixel_scan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pixel_scan_sequencer_pkg
// Shared definitions for the pixel scan sequencer and its index tracker:
//   - FSM state encodings (IDLE, START, SETTLE, REQ, ADVANCE, DONE)
//   - state register width
//   - indexWidth(): bit width needed to index a row or column of the matrix
// -----------------------------------------------------------------------------
package pixel_scan_sequencer_pkg;

   localparam int STATE_WIDTH = 3;

   localparam logic [2:0] STATE_IDLE    = 3'd0;
   localparam logic [2:0] STATE_START   = 3'd1;
   localparam logic [2:0] STATE_SETTLE  = 3'd2;
   localparam logic [2:0] STATE_REQ     = 3'd3;
   localparam logic [2:0] STATE_ADVANCE = 3'd4;
   localparam logic [2:0] STATE_DONE    = 3'd5;

   // A single-entry dimension still needs a one-bit index port.
   function automatic int indexWidth(input int length);
      return (length > 1) ? $clog2(length) : 1;
   endfunction

endpackage

// File: rtl/pixel_scan_index_tracker.sv
// -----------------------------------------------------------------------------
// pixel_scan_index_tracker
// Mirrors the scanner's row/column position and counts completed frames.
// Column runs fastest, then row; the frame counter steps when the last pixel
// of the matrix is advanced past and wraps modulo 2^FRAME_WIDTH.
// Ports:
//   clock_i           in   clock, rising edge
//   reset_i           in   synchronous reset, active-high
//   clear_i           in   zero row, col and frame count (new scan)
//   advance_i         in   step to the next pixel
//   row_o / col_o     out  current pixel index
//   last_pixel_o      out  current pixel is (ROW_LENGTH-1, COLUMN_LENGTH-1)
//   frame_cnt_o       out  frames completed since the last clear
//   frame_cnt_next_o  out  frame count after the current frame completes
// -----------------------------------------------------------------------------
module pixel_scan_index_tracker
   import pixel_scan_sequencer_pkg::*;
#(
   parameter int ROW_LENGTH    = 32,
   parameter int COLUMN_LENGTH = 8,
   parameter int FRAME_WIDTH   = 16
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic                                 clear_i,
   input  logic                                 advance_i,
   output logic [indexWidth(ROW_LENGTH)-1:0]    row_o,
   output logic [indexWidth(COLUMN_LENGTH)-1:0] col_o,
   output logic                                 last_pixel_o,
   output logic [FRAME_WIDTH-1:0]               frame_cnt_o,
   output logic [FRAME_WIDTH-1:0]               frame_cnt_next_o
);

   localparam int RW = indexWidth(ROW_LENGTH);
   localparam int CW = indexWidth(COLUMN_LENGTH);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROW_LENGTH - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLUMN_LENGTH - 1);

   logic [RW-1:0]          row_q, row_d;
   logic [CW-1:0]          col_q, col_d;
   logic [FRAME_WIDTH-1:0] frameCnt_q, frameCnt_d;
   logic                   rowLast, colLast;

   assign rowLast = (row_q == ROW_LAST);
   assign colLast = (col_q == COL_LAST);

   always_comb begin
      row_d      = row_q;
      col_d      = col_q;
      frameCnt_d = frameCnt_q;
      if (clear_i) begin
         row_d      = '0;
         col_d      = '0;
         frameCnt_d = '0;
      end else if (advance_i) begin
         if (colLast) begin
            col_d = '0;
            if (rowLast) begin
               row_d      = '0;
               frameCnt_d = frameCnt_q + FRAME_WIDTH'(1);
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         row_q      <= '0;
         col_q      <= '0;
         frameCnt_q <= '0;
      end else begin
         row_q      <= row_d;
         col_q      <= col_d;
         frameCnt_q <= frameCnt_d;
      end
   end

   assign row_o            = row_q;
   assign col_o            = col_q;
   assign last_pixel_o     = rowLast && colLast;
   assign frame_cnt_o      = frameCnt_q;
   assign frame_cnt_next_o = frameCnt_q + FRAME_WIDTH'(1);

endmodule

// File: rtl/pixel_scan_sequencer.sv
// -----------------------------------------------------------------------------
// pixel_scan_sequencer
// Drives the pixel digital-scan chain: start pulse, per-pixel dwell, readout
// request/handshake, then one speak (advance) pulse per pixel. Counts frames
// and stops after the programmed number (0 = run until aborted).
// Ports:
//   clock_i, reset_i       clock and synchronous active-high reset
//   cmd_start_i            start request (IDLE only); latches dwell_i, frames_i
//   cmd_abort_i            return to IDLE from any state, indices hold
//   dwell_i                settle cycles per pixel minus one
//   frames_i               frames to scan, 0 = continuous
//   rd_ready_i             readout accepts the current pixel
//   scan_start_o           one-cycle pulse to the scanner's start_i
//   scan_speak_o           one-cycle pulse to the scanner's speak_i
//   rd_valid_o             pixel settled, readout requested
//   rd_row_o / rd_col_o    index of the current pixel
//   frame_cnt_o            frames completed since the last start
//   busy_o                 high outside IDLE
//   done_o                 one-cycle pulse when the programmed frames complete
// All outputs decode from registered state only.
// -----------------------------------------------------------------------------
module pixel_scan_sequencer
   import pixel_scan_sequencer_pkg::*;
#(
   parameter int ROW_LENGTH    = 32,
   parameter int COLUMN_LENGTH = 8,
   parameter int DWELL_WIDTH   = 8,
   parameter int FRAME_WIDTH   = 16
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic                                 cmd_start_i,
   input  logic                                 cmd_abort_i,
   input  logic [DWELL_WIDTH-1:0]               dwell_i,
   input  logic [FRAME_WIDTH-1:0]               frames_i,
   input  logic                                 rd_ready_i,
   output logic                                 scan_start_o,
   output logic                                 scan_speak_o,
   output logic                                 rd_valid_o,
   output logic [indexWidth(ROW_LENGTH)-1:0]    rd_row_o,
   output logic [indexWidth(COLUMN_LENGTH)-1:0] rd_col_o,
   output logic [FRAME_WIDTH-1:0]               frame_cnt_o,
   output logic                                 busy_o,
   output logic                                 done_o
);

   logic [STATE_WIDTH-1:0] state_q, state_d;
   logic [DWELL_WIDTH-1:0] dwellCnt_q, dwellCnt_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
   logic [FRAME_WIDTH-1:0] frames_q, frames_d;
   logic [FRAME_WIDTH-1:0] frameCntNext;
   logic                   lastPixel;
   logic                   startAccept;
   logic                   advance;

   assign startAccept = (state_q == STATE_IDLE) && cmd_start_i && !cmd_abort_i;
   // An abort landing on the ADVANCE cycle leaves the mirror where it was.
   assign advance     = (state_q == STATE_ADVANCE) && !cmd_abort_i;

   pixel_scan_index_tracker #(
      .ROW_LENGTH    (ROW_LENGTH),
      .COLUMN_LENGTH (COLUMN_LENGTH),
      .FRAME_WIDTH   (FRAME_WIDTH)
   ) u_tracker (
      .clock_i          (clock_i),
      .reset_i          (reset_i),
      .clear_i          (startAccept),
      .advance_i        (advance),
      .row_o            (rd_row_o),
      .col_o            (rd_col_o),
      .last_pixel_o     (lastPixel),
      .frame_cnt_o      (frame_cnt_o),
      .frame_cnt_next_o (frameCntNext)
   );

   // The dwell counter is zeroed on every path into SETTLE (from START and
   // ADVANCE), so SETTLE always lasts exactly dwell_q+1 cycles.
   always_comb begin
      state_d    = state_q;
      dwellCnt_d = dwellCnt_q;
      dwell_d    = dwell_q;
      frames_d   = frames_q;
      case (state_q)
         STATE_IDLE: begin
            if (startAccept) begin
               state_d  = STATE_START;
               dwell_d  = dwell_i;
               frames_d = frames_i;
            end
         end
         STATE_START: begin
            state_d    = STATE_SETTLE;
            dwellCnt_d = '0;
         end
         STATE_SETTLE: begin
            if (dwellCnt_q == dwell_q) begin
               state_d = STATE_REQ;
            end else begin
               dwellCnt_d = dwellCnt_q + DWELL_WIDTH'(1);
            end
         end
         STATE_REQ: begin
            if (rd_ready_i) begin
               state_d = STATE_ADVANCE;
            end
         end
         STATE_ADVANCE: begin
            dwellCnt_d = '0;
            if (lastPixel && (frames_q != '0) && (frameCntNext == frames_q)) begin
               state_d = STATE_DONE;
            end else begin
               state_d = STATE_SETTLE;
            end
         end
         STATE_DONE: begin
            state_d = STATE_IDLE;
         end
         default: begin
            state_d = STATE_IDLE;
         end
      endcase
      if ((state_q != STATE_IDLE) && cmd_abort_i) begin
         state_d = STATE_IDLE;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= STATE_IDLE;
         dwellCnt_q <= '0;
         dwell_q    <= '0;
         frames_q   <= '0;
      end else begin
         state_q    <= state_d;
         dwellCnt_q <= dwellCnt_d;
         dwell_q    <= dwell_d;
         frames_q   <= frames_d;
      end
   end

   assign scan_start_o = (state_q == STATE_START);
   assign scan_speak_o = (state_q == STATE_ADVANCE);
   assign rd_valid_o   = (state_q == STATE_REQ);
   assign busy_o       = (state_q != STATE_IDLE);
   assign done_o       = (state_q == STATE_DONE);

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pixel_scan_sequencer
// Self-checking bench for pixel_scan_sequencer on a 4x2 matrix. Expected pixel
// indices are queued when a scan is started and popped on each handshake.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pixel_scan_sequencer;

   localparam int ROWS = 4;
   localparam int COLS = 2;
   localparam int DW   = 8;
   localparam int FW   = 16;

   logic          clock;
   logic          reset;
   logic          cmdStart;
   logic          cmdAbort;
   logic [DW-1:0] dwellIn;
   logic [FW-1:0] framesIn;
   logic          rdReady;
   logic          scanStart;
   logic          scanSpeak;
   logic          rdValid;
   logic [1:0]    rdRow;
   logic [0:0]    rdCol;
   logic [FW-1:0] frameCnt;
   logic          busy;
   logic          done;

   int         checks   = 0;
   int         failures = 0;
   logic [2:0] expQ[$];

   pixel_scan_sequencer #(
      .ROW_LENGTH    (ROWS),
      .COLUMN_LENGTH (COLS),
      .DWELL_WIDTH   (DW),
      .FRAME_WIDTH   (FW)
   ) dut (
      .clock_i      (clock),
      .reset_i      (reset),
      .cmd_start_i  (cmdStart),
      .cmd_abort_i  (cmdAbort),
      .dwell_i      (dwellIn),
      .frames_i     (framesIn),
      .rd_ready_i   (rdReady),
      .scan_start_o (scanStart),
      .scan_speak_o (scanSpeak),
      .rd_valid_o   (rdValid),
      .rd_row_o     (rdRow),
      .rd_col_o     (rdCol),
      .frame_cnt_o  (frameCnt),
      .busy_o       (busy),
      .done_o       (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Queue one frame of expected indices, column fastest.
   task automatic pushFrame();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            expQ.push_back({2'(r), 1'(c)});
         end
      end
   endtask

   // Called at a falling edge; returns at the falling edge of the START cycle.
   task automatic pulseStart(input logic [FW-1:0] frames, input logic [DW-1:0] dwell);
      framesIn = frames;
      dwellIn  = dwell;
      cmdStart = 1'b1;
      @(negedge clock);
      cmdStart = 1'b0;
      framesIn = FW'($urandom);
      dwellIn  = DW'($urandom);
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      cmdStart = 1'b0;
      cmdAbort = 1'b0;
      rdReady  = 1'b0;
      dwellIn  = '0;
      framesIn = '0;
      repeat (3) @(negedge clock);
      checks++;
      if ({scanStart, scanSpeak, rdValid, rdRow, rdCol, frameCnt, busy, done} !== 24'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%h expected=0",
                  {scanStart, scanSpeak, rdValid, rdRow, rdCol, frameCnt, busy, done});
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || scanStart !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_after_reset busy=%b start=%b expected 0 0", busy, scanStart);
      end
   endtask

   task automatic test_single_frame();
      int k = 1, speaks = 0, dones = 0, starts = 0, lastSpeak = 0;
      logic expectSpeak = 1'b0;
      logic finished = 1'b0;
      logic [2:0] exp;
      expQ.delete();
      pushFrame();
      rdReady = 1'b1;
      pulseStart(16'd1, 8'd2);
      while (!finished && k <= 200) begin
         if (scanStart) starts++;
         checks++;
         if (scanStart !== (k == 1)) begin
            failures++;
            $display("[TB] FAIL single_start_pulse cycle=%0d got=%b expected=%b", k, scanStart, (k == 1));
         end
         checks++;
         if (scanSpeak !== expectSpeak) begin
            failures++;
            $display("[TB] FAIL single_speak cycle=%0d got=%b expected=%b", k, scanSpeak, expectSpeak);
         end
         if (scanSpeak) begin
            if (speaks > 0) begin
               checks++;
               if (k - lastSpeak != 5) begin
                  failures++;
                  $display("[TB] FAIL speak_spacing got=%0d expected=5", k - lastSpeak);
               end
            end
            lastSpeak = k;
            speaks++;
         end
         if (k == 5) begin
            checks++;
            if (rdValid !== 1'b1) begin
               failures++;
               $display("[TB] FAIL first_valid_latency rd_valid=%b expected=1 at cycle 5", rdValid);
            end
         end
         expectSpeak = rdValid && rdReady;
         if (rdValid && rdReady) begin
            checks++;
            if (expQ.size() == 0) begin
               failures++;
               $display("[TB] FAIL single_extra_handshake got row=%0d col=%0d expected none", rdRow, rdCol);
            end else begin
               exp = expQ.pop_front();
               if ({rdRow, rdCol} !== exp) begin
                  failures++;
                  $display("[TB] FAIL single_index got=%b expected=%b", {rdRow, rdCol}, exp);
               end
            end
         end
         if (done) begin
            dones++;
            finished = 1'b1;
            checks++;
            if (k != 42) begin
               failures++;
               $display("[TB] FAIL done_latency got cycle=%0d expected=42", k);
            end
         end else begin
            @(negedge clock);
            k++;
         end
      end
      if (!finished) begin
         checks++;
         failures++;
         $display("[TB] FAIL single_timeout no done_o within 200 cycles");
      end
      @(negedge clock);
      checks++;
      if (speaks != 8 || starts != 1 || dones != 1 || expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL single_totals speaks=%0d starts=%0d dones=%0d left=%0d expected 8 1 1 0",
                  speaks, starts, dones, expQ.size());
      end
      checks++;
      if (frameCnt !== 16'd1 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_final frame=%0d busy=%b done=%b expected 1 0 0", frameCnt, busy, done);
      end
      rdReady = 1'b0;
   endtask

   task automatic test_stall();
      int k = 1;
      logic finished = 1'b0;
      logic stalled  = 1'b0;
      logic [2:0] exp;
      expQ.delete();
      pushFrame();
      rdReady = 1'b0;
      pulseStart(16'd1, 8'd1);
      while (!finished && k <= 300) begin
         if (rdValid) begin
            if (!stalled && rdRow == 2'd1 && rdCol == 1'b0) begin
               stalled = 1'b1;
               repeat (5) begin
                  @(negedge clock);
                  k++;
                  checks++;
                  if (rdValid !== 1'b1 || rdRow !== 2'd1 || rdCol !== 1'b0 || scanSpeak !== 1'b0) begin
                     failures++;
                     $display("[TB] FAIL stall_hold valid=%b row=%0d col=%0d speak=%b expected 1 1 0 0",
                              rdValid, rdRow, rdCol, scanSpeak);
                  end
               end
            end
            rdReady = 1'b1;
            checks++;
            if (expQ.size() == 0) begin
               failures++;
               $display("[TB] FAIL stall_extra_handshake got row=%0d col=%0d expected none", rdRow, rdCol);
            end else begin
               exp = expQ.pop_front();
               if ({rdRow, rdCol} !== exp) begin
                  failures++;
                  $display("[TB] FAIL stall_index got=%b expected=%b", {rdRow, rdCol}, exp);
               end
            end
            @(negedge clock);
            k++;
            rdReady = 1'b0;
            checks++;
            if (scanSpeak !== 1'b1) begin
               failures++;
               $display("[TB] FAIL stall_speak got=%b expected=1", scanSpeak);
            end
         end
         if (done) begin
            finished = 1'b1;
         end else begin
            @(negedge clock);
            k++;
         end
      end
      checks++;
      if (!finished || !stalled || expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL stall_completion done=%b stalled=%b left=%0d expected 1 1 0",
                  finished, stalled, expQ.size());
      end
      @(negedge clock);
   endtask

   task automatic test_abort();
      int k = 0;
      logic aborted = 1'b0;
      logic [2:0] exp;
      expQ.delete();
      pushFrame();
      rdReady = 1'b0;
      pulseStart(16'd1, 8'd1);
      while (!aborted && k <= 200) begin
         if (rdValid) begin
            checks++;
            if (expQ.size() == 0) begin
               failures++;
               $display("[TB] FAIL abort_extra_handshake got row=%0d col=%0d", rdRow, rdCol);
            end else begin
               exp = expQ.pop_front();
               if ({rdRow, rdCol} !== exp) begin
                  failures++;
                  $display("[TB] FAIL abort_index got=%b expected=%b", {rdRow, rdCol}, exp);
               end
            end
            if (exp == 3'b101) begin
               cmdAbort = 1'b1;
               aborted  = 1'b1;
            end else begin
               rdReady = 1'b1;
            end
         end
         @(negedge clock);
         k++;
         rdReady  = 1'b0;
         cmdAbort = 1'b0;
      end
      checks++;
      if (!aborted || rdValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || scanSpeak !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_idle aborted=%b valid=%b busy=%b done=%b speak=%b expected 1 0 0 0 0",
                  aborted, rdValid, busy, done, scanSpeak);
      end
      checks++;
      if (rdRow !== 2'd2 || rdCol !== 1'b1 || frameCnt !== 16'd0) begin
         failures++;
         $display("[TB] FAIL abort_hold row=%0d col=%0d frame=%0d expected 2 1 0", rdRow, rdCol, frameCnt);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_no_done done=%b busy=%b expected 0 0", done, busy);
      end
      expQ.delete();
      pushFrame();
      pulseStart(16'd1, 8'd1);
      checks++;
      if (scanStart !== 1'b1 || rdRow !== 2'd0 || rdCol !== 1'b0 || frameCnt !== 16'd0) begin
         failures++;
         $display("[TB] FAIL restart start=%b row=%0d col=%0d frame=%0d expected 1 0 0 0",
                  scanStart, rdRow, rdCol, frameCnt);
      end
      repeat (3) @(negedge clock);
      checks++;
      exp = expQ.pop_front();
      if (rdValid !== 1'b1 || {rdRow, rdCol} !== exp) begin
         failures++;
         $display("[TB] FAIL restart_first_pixel valid=%b index=%b expected 1 %b", rdValid, {rdRow, rdCol}, exp);
      end
      cmdAbort = 1'b1;
      @(negedge clock);
      cmdAbort = 1'b0;
      expQ.delete();
   endtask

   task automatic test_continuous();
      int k = 1, hs = 0, lastHs = 0;
      logic expectSpeak = 1'b0;
      logic [2:0] exp;
      expQ.delete();
      repeat (3) pushFrame();
      rdReady = 1'b0;
      pulseStart(16'd0, 8'd0);
      while (hs < 24 && k <= 400) begin
         cmdStart = 1'b0;
         if (k > 1) begin
            checks++;
            if (scanStart !== 1'b0 || done !== 1'b0) begin
               failures++;
               $display("[TB] FAIL cont_no_start_done cycle=%0d start=%b done=%b expected 0 0", k, scanStart, done);
            end
         end
         checks++;
         if (scanSpeak !== expectSpeak) begin
            failures++;
            $display("[TB] FAIL cont_speak cycle=%0d got=%b expected=%b", k, scanSpeak, expectSpeak);
         end
         expectSpeak = 1'b0;
         rdReady     = 1'b0;
         if (rdValid) begin
            rdReady     = 1'b1;
            expectSpeak = 1'b1;
            checks++;
            if (frameCnt !== 16'(hs / 8)) begin
               failures++;
               $display("[TB] FAIL cont_frame_cnt at handshake %0d got=%0d expected=%0d", hs, frameCnt, hs / 8);
            end
            if (hs > 0) begin
               checks++;
               if (k - lastHs != 3) begin
                  failures++;
                  $display("[TB] FAIL cont_period got=%0d expected=3", k - lastHs);
               end
            end
            checks++;
            exp = expQ.pop_front();
            if ({rdRow, rdCol} !== exp) begin
               failures++;
               $display("[TB] FAIL cont_index got=%b expected=%b", {rdRow, rdCol}, exp);
            end
            lastHs = k;
            hs++;
            if (hs == 5 || hs == 13) begin
               cmdStart = 1'b1;
               framesIn = 16'd1;
               dwellIn  = 8'd7;
            end
         end
         @(negedge clock);
         k++;
      end
      cmdStart = 1'b0;
      rdReady  = 1'b0;
      checks++;
      if (hs != 24) begin
         failures++;
         $display("[TB] FAIL cont_timeout handshakes=%0d expected=24", hs);
      end
      @(negedge clock);
      checks++;
      if (frameCnt !== 16'd3 || busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL cont_final frame=%0d busy=%b done=%b expected 3 1 0", frameCnt, busy, done);
      end
      cmdAbort = 1'b1;
      @(negedge clock);
      cmdAbort = 1'b0;
      checks++;
      if (busy !== 1'b0 || frameCnt !== 16'd3) begin
         failures++;
         $display("[TB] FAIL cont_abort busy=%b frame=%0d expected 0 3", busy, frameCnt);
      end
   endtask

   task automatic test_reset_mid();
      pulseStart(16'd0, 8'd5);
      @(negedge clock);
      checks++;
      if (busy !== 1'b1 || scanStart !== 1'b0 || rdValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_settle busy=%b start=%b valid=%b expected 1 0 0", busy, scanStart, rdValid);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if ({scanStart, scanSpeak, rdValid, rdRow, rdCol, frameCnt, busy, done} !== 24'd0) begin
         failures++;
         $display("[TB] FAIL mid_reset_outputs got=%h expected=0",
                  {scanStart, scanSpeak, rdValid, rdRow, rdCol, frameCnt, busy, done});
      end
      repeat (6) begin
         @(negedge clock);
         checks++;
         if (busy !== 1'b0 || scanStart !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_stays_idle busy=%b start=%b expected 0 0", busy, scanStart);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_stall();
      test_abort();
      test_continuous();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
